// File: rtl/ram_sdp_be_rl.sv
// Simple-dual-port RAM with byte-enable writes, a 1- or 2-cycle registered read,
// and a zero-sweep clear engine that runs after reset or on a clr pulse.
module ram_sdp_be_rl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    clr,
    output logic                    init_busy
);

    localparam int                    NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_next;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
    logic                    wr_hit, rd_hit, rd_in_range;
    logic [DATA_WIDTH-1:0]   rd_word;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            CLEAR: begin
                // Compare against the last real word so non-power-of-two depths stop on time.
                if (clr_addr == LAST_ADDR) begin
                    state_next    = IDLE;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr + ADDR_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign init_busy   = (state == CLEAR);
    assign wr_hit      = !init_busy && wr_en && ({1'b0, wr_addr} < DEPTH);
    assign rd_hit      = !init_busy && rd_en;
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH);

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
        end
        if (RDW_MODE != 0 && wr_hit && wr_addr == rd_addr) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // NOTE: the array has no reset; contents are zeroed only by the clear sweep.
    always_ff @(posedge clk) begin
        if (init_busy) begin
            mem[clr_addr] <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_rl2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    s1_valid <= rd_hit;
                    if (rd_hit) begin
                        s1_data <= rd_word;
                    end
                    rd_valid <= s1_valid;
                    if (s1_valid) begin
                        rd_data <= s1_data;
                    end
                end
            end
        end else begin : g_rl1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_hit;
                    if (rd_hit) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be_rl.sv
// Bench for ram_sdp_be_rl: two configurations share one stimulus stream and are
// compared every cycle against an array-and-queue reference model.
module tb_ram_sdp_be_rl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        clr = 1'b0;

    logic [31:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid, a_init_busy, b_init_busy;

    always #5 clk = ~clk;

    // Configuration A: full depth, latency 1, old data on collision.
    ram_sdp_be_rl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(256),
        .READ_LATENCY(1), .RDW_MODE(0), .INIT_CLEAR(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .clr(clr), .init_busy(a_init_busy)
    );

    // Configuration B: depth 200, latency 2, new data on collision.
    ram_sdp_be_rl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RAM_DEPTH(200),
        .READ_LATENCY(2), .RDW_MODE(1), .INIT_CLEAR(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .clr(clr), .init_busy(b_init_busy)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    logic [31:0] mm [2][256];
    int          busy_left [2];
    logic [31:0] last_a, last_b;
    exp_t        qa[$], qb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        busy_left[0] = 256;
        busy_left[1] = 200;
    endtask

    // One rising edge of the reference model, using the inputs presented this cycle.
    task automatic model_edge();
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int d;
            d = (k == 0) ? 256 : 200;
            if (busy_left[k] > 0) begin
                mm[k][d - busy_left[k]] = '0;
                busy_left[k]--;
            end else begin
                if (rd_en) begin
                    logic [31:0] v;
                    v = (int'(rd_addr) < d) ? mm[k][rd_addr] : '0;
                    if (k == 1 && wr_en && wr_addr == rd_addr && int'(rd_addr) < d)
                        v = merge(v, wr_data, wr_be);
                    if (k == 0) qa.push_back('{cyc, v});
                    else        qb.push_back('{cyc + 1, v});
                end
                if (wr_en && int'(wr_addr) < d)
                    mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_be);
                if (clr) busy_left[k] = d;
            end
        end
    endtask

    task automatic compare_outputs();
        logic        ev;
        logic [31:0] ed;
        exp_t        e;
        ev = 1'b0;
        ed = last_a;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            ev = 1'b1;
            ed = e.val;
            last_a = ed;
        end
        check("a.rd_valid", 32'(a_rd_valid), 32'(ev));
        check("a.rd_data", a_rd_data, ed);
        check("a.init_busy", 32'(a_init_busy), 32'(busy_left[0] > 0));
        ev = 1'b0;
        ed = last_b;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            ev = 1'b1;
            ed = e.val;
            last_b = ed;
        end
        check("b.rd_valid", 32'(b_rd_valid), 32'(ev));
        check("b.rd_data", b_rd_data, ed);
        check("b.init_busy", 32'(b_init_busy), 32'(busy_left[1] > 0));
    endtask

    // Present inputs at the falling edge, advance one clock, compare at the next falling edge.
    task automatic drive(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [7:0] ra,
                         input logic c);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; rd_addr = ra; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_outputs();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mm[k][i] = '0;
        @(negedge clk);
        do_reset(3);

        // Requests during the power-up sweep must be ignored.
        for (int i = 0; i < 256; i++)
            drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'b0);

        for (int i = 0; i < 256; i++) drive(1'b0, '0, '0, '0, 1'b1, 8'(i), 1'b0);
        idle(2);

        // Byte-enable merge.
        drive(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h10, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 8'h10, 1'b0);
        check("be_merge", a_rd_data, 32'hDE22BE44);
        idle(2);

        // Back-to-back reads.
        drive(1'b1, 8'h01, 32'hA1, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h02, 32'hA2, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h03, 32'hA3, 4'hF, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 3; i++) drive(1'b0, '0, '0, '0, 1'b1, 8'(i), 1'b0);
        idle(3);

        // Same-address read during write.
        drive(1'b1, 8'h20, 32'h0, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b1, 8'h20, 32'hCAFEF00D, 4'hF, 1'b1, 8'h20, 1'b0);
        check("rdw_old", a_rd_data, 32'h0);
        idle(1);
        check("rdw_new", b_rd_data, 32'hCAFEF00D);
        idle(2);

        // Out-of-range write and read on the 200-deep instance.
        drive(1'b1, 8'd210, 32'h55, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 8'd210, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 8'd10, 1'b0);
        check("oob_valid", 32'(b_rd_valid), 32'h1);
        check("oob_data", b_rd_data, 32'h0);
        idle(3);

        // Clear with a read in the same cycle, reads while busy, then reset mid-sweep.
        drive(1'b1, 8'h7F, 32'h1234, 4'hF, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 8'h7F, 1'b1);
        check("clr_read", a_rd_data, 32'h1234);
        drive(1'b0, '0, '0, '0, 1'b1, 8'h7F, 1'b0);
        check("busy_no_valid", 32'(a_rd_valid), 32'h0);
        for (int i = 0; i < 40; i++) drive(1'b0, '0, '0, '0, 1'b1, 8'h7F, 1'($urandom_range(0, 1)));
        do_reset(2);
        idle(256);
        drive(1'b0, '0, '0, '0, 1'b1, 8'h7F, 1'b0);
        check("cleared_7f", a_rd_data, 32'h0);
        idle(2);

        // Random traffic with biased address collisions and occasional clears.
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] wa;
            wa = 8'($urandom);
            drive(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? wa : 8'($urandom),
                  1'($urandom_range(0, 299) == 0));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be_rl.md
Name: ram_sdp_be_rl

Overview:
Parametrised simple-dual-port RAM with one synchronous write port and one synchronous read port. Writes support per-byte enables. Read latency is configurable at 1 or 2 cycles and is tracked by a valid pipeline. A clear state machine zeroes the whole array after reset or on request. It replaces single-port async-read RAMs wherever a registered, byte-writable, concurrently readable buffer is needed.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address width in bits.
RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must not exceed 2^ADDR_WIDTH.
READ_LATENCY, 1, cycles from rd_en to rd_valid; legal values are 1 and 2.
RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new (byte-merged) data.
INIT_CLEAR, 1, 1 runs a zero-sweep after reset; 0 leaves the array uninitialised after reset.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; asynchronous, active-low
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data valid strobe, one cycle per accepted read
clr  in  1  single-cycle pulse that starts a full clear
init_busy  out  1  clear sweep in progress; all requests are ignored while high

Behaviour:
- Reset values: rd_data=0, rd_valid=0, all latency pipeline stages=0.
- Reset values (INIT_CLEAR=1): init_busy=1, FSM=CLEAR, clear address=0.
- Reset values (INIT_CLEAR=0): init_busy=0, FSM=IDLE.
- rst_n does not touch array contents directly.
- FSM state IDLE: normal operation.
  - clr=1 -> CLEAR on the next edge with clear address=0.
  - init_busy rises the cycle after clr.
- FSM state CLEAR: writes all-zero to the clear address every cycle, then increments the address.
  - After writing RAM_DEPTH-1 -> IDLE.
  - The sweep takes exactly RAM_DEPTH cycles; init_busy drops the cycle after the last write.
  - clr during CLEAR is ignored; the sweep is not restarted.
- While init_busy=1: wr_en and rd_en are ignored, and no rd_valid is generated for them.
  - Reads already in the pipeline when clr arrives still complete.
- Write (IDLE, wr_en=1, wr_addr<RAM_DEPTH): on the clock edge, bytes with wr_be[i]=1 are updated; other bytes are kept.
  - wr_be=0 is a legal no-op.
- Read (IDLE, rd_en=1): accepted unconditionally.
  - READ_LATENCY=1: rd_data and rd_valid are updated on the edge that samples rd_en.
  - READ_LATENCY=2: an extra output register stage adds one cycle.
  - Back-to-back reads give one rd_valid per cycle, in order.
- rd_data holds its last value when rd_valid=0.
- Out of range (address>=RAM_DEPTH):
  - Writes are dropped.
  - Reads return 0 with rd_valid asserted normally.
- Same-address read and write in one cycle:
  - RDW_MODE=0: pre-write word.
  - RDW_MODE=1: word with enabled bytes replaced by wr_data.
- Different addresses in one cycle: fully independent.
- rst_n asserted mid-operation:
  - Pipeline is flushed immediately and rd_valid=0; in-flight reads are lost.
  - With INIT_CLEAR=1 the sweep restarts from address 0 after release.
- Widths: wr_be width is DATA_WIDTH/8. The clear address counter is ADDR_WIDTH bits and compares against RAM_DEPTH-1, so non-power-of-two depths terminate correctly.

Test Plan:
- Reset release, INIT_CLEAR=1, RAM_DEPTH=256 -> init_busy high for exactly 256 cycles; then a read of every address returns 0x00000000 with rd_valid one cycle after rd_en.
- Write 0xDEADBEEF to 0x10 with be=4'hF, then write 0x11223344 with be=4'b0101, then read 0x10 -> 0xDE22BE44.
- READ_LATENCY=2, reads to 0x01, 0x02, 0x03 on consecutive cycles (holding 0xA1, 0xA2, 0xA3) -> rd_valid high on cycles 2, 3, 4 after the first rd_en, with data in order.
- Address 0x20 holds 0x0; same-cycle write 0xCAFEF00D be=4'hF and read 0x20 -> RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0xCAFEF00D.
- RAM_DEPTH=200, write 0x55 to address 210, then read 210 -> rd_valid=1, rd_data=0; address 210 mod 200 is unchanged.
- clr pulse while 0x7F holds 0x1234, with a read issued the same cycle -> that read completes; a later rd_en during init_busy gives no rd_valid; after the sweep, 0x7F reads 0x0. rst_n low mid-sweep restarts the sweep from 0.
